// File: rtl/pipelined_instr_decoder.sv
// Two-stage streaming instruction decoder: S1 captures the instruction and its sequence tag,
// S2 holds the decoded op_class/addr_mode. Optional statistics counters under DECODER_STATS_EN.
module pipelined_instr_decoder #(
    parameter int INSTR_W = 8,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         op_class,
    output logic [2:0]         addr_mode,
    output logic               illegal,
    output logic [TAG_W-1:0]   tag
`ifdef DECODER_STATS_EN
    ,
    input  logic               stats_clr,
    output logic [CNT_W-1:0]   cnt_load,
    output logic [CNT_W-1:0]   cnt_store,
    output logic [CNT_W-1:0]   cnt_jump,
    output logic [CNT_W-1:0]   cnt_branch,
    output logic [CNT_W-1:0]   cnt_illegal
`endif
);

    localparam logic [2:0] UNKNOWN = 3'd7;

    // Explicit equality compares: an X/Z field never matches and falls through to UNKNOWN.
    function automatic logic [2:0] decode_field(input logic [2:0] f);
        if (f == 3'b000)      return 3'd0;
        else if (f == 3'b001) return 3'd1;
        else if (f == 3'b010) return 3'd2;
        else if (f == 3'b011) return 3'd3;
        else                  return UNKNOWN;
    endfunction

    logic               r_s1_valid;
    logic [INSTR_W-1:0] r_s1_instr;
    logic [TAG_W-1:0]   r_s1_tag;
    logic [TAG_W-1:0]   r_tag_cnt;
    logic               r_s2_valid;
    logic [2:0]         r_s2_op;
    logic [2:0]         r_s2_mode;
    logic               r_s2_ill;
    logic [TAG_W-1:0]   r_s2_tag;

    logic               w_s2_load;
    logic               w_in_fire;
    logic               w_out_fire;
    logic [2:0]         w_dec_op;
    logic [2:0]         w_dec_mode;
    logic               w_unused_mid;

    // Valid/ready: a transfer happens on a clk edge where valid & ready are both high;
    // valid and its payload stay stable until that edge, and ready never waits on valid.
    assign w_s2_load  = ~r_s2_valid | out_ready;
    assign in_ready   = ~rst & (~r_s1_valid | w_s2_load);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_s2_valid & out_ready;

    assign w_dec_op     = decode_field(r_s1_instr[INSTR_W-1 -: 3]);
    assign w_dec_mode   = decode_field(r_s1_instr[2:0]);
    assign w_unused_mid = ^r_s1_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_instr <= '0;
            r_s1_tag   <= '0;
            r_tag_cnt  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_op    <= UNKNOWN;
            r_s2_mode  <= UNKNOWN;
            r_s2_ill   <= 1'b0;
            r_s2_tag   <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_instr <= instr;
                r_s1_tag   <= r_tag_cnt;
                r_tag_cnt  <= r_tag_cnt + TAG_W'(1);
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            // Payload only moves with a real instruction so a bubble leaves the last result visible.
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_op   <= w_dec_op;
                    r_s2_mode <= w_dec_mode;
                    r_s2_ill  <= (w_dec_op == UNKNOWN) | (w_dec_mode == UNKNOWN);
                    r_s2_tag  <= r_s1_tag;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign op_class  = r_s2_op;
    assign addr_mode = r_s2_mode;
    assign illegal   = r_s2_ill;
    assign tag       = r_s2_tag;

`ifdef DECODER_STATS_EN
    logic [CNT_W-1:0] r_cnt_load;
    logic [CNT_W-1:0] r_cnt_store;
    logic [CNT_W-1:0] r_cnt_jump;
    logic [CNT_W-1:0] r_cnt_branch;
    logic [CNT_W-1:0] r_cnt_illegal;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic hit);
        if (hit && (c != '1)) return c + CNT_W'(1);
        else                  return c;
    endfunction

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            r_cnt_load    <= '0;
            r_cnt_store   <= '0;
            r_cnt_jump    <= '0;
            r_cnt_branch  <= '0;
            r_cnt_illegal <= '0;
        end else begin
            r_cnt_load    <= sat_inc(r_cnt_load,    w_out_fire & (r_s2_op == 3'd0));
            r_cnt_store   <= sat_inc(r_cnt_store,   w_out_fire & (r_s2_op == 3'd1));
            r_cnt_jump    <= sat_inc(r_cnt_jump,    w_out_fire & (r_s2_op == 3'd2));
            r_cnt_branch  <= sat_inc(r_cnt_branch,  w_out_fire & (r_s2_op == 3'd3));
            r_cnt_illegal <= sat_inc(r_cnt_illegal, w_out_fire & r_s2_ill);
        end
    end

    assign cnt_load    = r_cnt_load;
    assign cnt_store   = r_cnt_store;
    assign cnt_jump    = r_cnt_jump;
    assign cnt_branch  = r_cnt_branch;
    assign cnt_illegal = r_cnt_illegal;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    logic             w_unused_fire;
    assign w_unused_cnt  = '0;
    assign w_unused_fire = w_out_fire;
`endif

endmodule

// File: tb/tb_pipelined_instr_decoder.sv
// Directed bench for pipelined_instr_decoder: decode table, latency, backpressure,
// tag wrap, mid-stream reset, and saturating counters when DECODER_STATS_EN is defined.
module tb_pipelined_instr_decoder;
  localparam int INSTR_W = 8;
  localparam int TAG_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         op_class;
  logic [2:0]         addr_mode;
  logic               illegal;
  logic [TAG_W-1:0]   tag;
`ifdef DECODER_STATS_EN
  logic               stats_clr;
  logic [CNT_W-1:0]   cnt_load, cnt_store, cnt_jump, cnt_branch, cnt_illegal;
`endif

  pipelined_instr_decoder #(.INSTR_W(INSTR_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .op_class(op_class),
    .addr_mode(addr_mode), .illegal(illegal), .tag(tag)
`ifdef DECODER_STATS_EN
    , .stats_clr(stats_clr), .cnt_load(cnt_load), .cnt_store(cnt_store),
    .cnt_jump(cnt_jump), .cnt_branch(cnt_branch), .cnt_illegal(cnt_illegal)
`endif
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [INSTR_W-1:0] instr;
    logic [2:0]         op;
    logic [2:0]         mode;
    logic               ill;
  } vec_t;
  vec_t vecs[8];

  int n_chk  = 0;
  int n_pass = 0;
  int n_out  = 0;
  logic [TAG_W-1:0] last_tag;
  bit lat_en = 1'b0;

  // scoreboard: {op, mode, ill, tag}
  logic [10:0]      exp_q[$];
  int               cyc_q[$];
  bit               lat_q[$];
  logic [TAG_W-1:0] m_tag;
  logic [2:0]       cur_op, cur_mode;
  logic             cur_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); cyc_q.delete(); lat_q.delete();
      m_tag = '0;
    end else begin
      if (out_valid && out_ready) begin
        chk("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [10:0] e;
          int c;
          bit l;
          e = exp_q.pop_front(); c = cyc_q.pop_front(); l = lat_q.pop_front();
          chk("op_class", op_class, e[10:8]);
          chk("addr_mode", addr_mode, e[7:5]);
          chk("illegal", illegal, e[4]);
          chk("tag", tag, e[3:0]);
          if (l) chk("latency", cyc, c + 2);
          last_tag = tag;
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({cur_op, cur_mode, cur_ill, m_tag});
        cyc_q.push_back(cyc);
        lat_q.push_back(lat_en);
        m_tag = m_tag + 1'b1;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input vec_t v);
    int n;
    bit acc;
    in_valid = 1'b1; instr = v.instr;
    cur_op = v.op; cur_mode = v.mode; cur_ill = v.ill;
    n = 0;
    do begin
      #1; acc = in_ready;
      tick(); n++;
    end while (!acc && n < 30);
    chk("send_accepted", acc, 1);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin tick(); n++; end
    tick();
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    vecs[0] = '{8'b00000000, 3'd0, 3'd0, 1'b0};
    vecs[1] = '{8'b00100001, 3'd1, 3'd1, 1'b0};
    vecs[2] = '{8'b01001010, 3'd2, 3'd2, 1'b0};
    vecs[3] = '{8'b01111011, 3'd3, 3'd3, 1'b0};
    vecs[4] = '{8'b10000000, 3'd7, 3'd0, 1'b1};
    vecs[5] = '{8'b00011111, 3'd0, 3'd7, 1'b1};
    vecs[6] = '{8'b11100110, 3'd7, 3'd7, 1'b1};
    vecs[7] = '{8'b01011101, 3'd2, 3'd7, 1'b1};

    rst = 1'b1; in_valid = 1'b1; instr = '0; out_ready = 1'b1;
    cur_op = '0; cur_mode = '0; cur_ill = 1'b0;
`ifdef DECODER_STATS_EN
    stats_clr = 1'b0;
`endif

    // reset held with in_valid=1
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_tag", tag, 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_op", op_class, 7);
    chk("post_rst_mode", addr_mode, 7);
    chk("post_rst_ill", illegal, 0);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);
    tick();

    // back-to-back streaming of the decode table, latency checked
    lat_en = 1'b1;
    for (int i = 0; i < 8; i++) send(vecs[i]);
    drain();
    lat_en = 1'b0;
    chk("stream_count", n_out, 8);

    // backpressure: two fill the pipe, third waits
    out_ready = 1'b0;
    n0 = n_out;
    send(vecs[2]);
    send(vecs[3]);
    in_valid = 1'b1; instr = vecs[0].instr;
    cur_op = vecs[0].op; cur_mode = vecs[0].mode; cur_ill = vecs[0].ill;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hold_op", op_class, 2);
      chk("bp_hold_mode", addr_mode, 2);
      chk("bp_hold_tag", tag, 8);
      tick(); #1;
    end
    out_ready = 1'b1;
    send(vecs[0]);
    drain();
    chk("bp_count", n_out - n0, 3);

    // tag wrap after a fresh reset
    rst = 1'b1; tick(); rst = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 17; i++) send(vecs[i % 4]);
    drain();
    chk("wrap_count", n_out - n0, 17);
    chk("wrap_tag17", last_tag, 0);

    // reset with two results in flight
    send(vecs[1]);
    send(vecs[2]);
    chk("mid_out_valid_before", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    tick();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_tag", tag, 0);
    rst = 1'b0; in_valid = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_replay", out_valid, 0);
    end
    chk("no_replay_count", n_out - n0, 0);
    send(vecs[3]);
    drain();
    chk("post_mid_tag", last_tag, 0);

`ifdef DECODER_STATS_EN
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 5; i++) send(vecs[0]);
    drain();
    chk("cnt_load_sat", cnt_load, 3);
    chk("cnt_store_zero", cnt_store, 0);
    send(vecs[4]);
    drain();
    chk("cnt_illegal", cnt_illegal, 1);
    send(vecs[0]);
    send(vecs[0]);
    in_valid = 1'b0;
    stats_clr = 1'b1;
    chk("clr_during_xfer", out_valid & out_ready, 1);
    tick();
    stats_clr = 1'b0;
    chk("cnt_load_clr", cnt_load, 0);
    chk("cnt_illegal_clr", cnt_illegal, 0);
    drain();
    chk("cnt_load_after_clr", cnt_load, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
